// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 codes, FSM states, size and alignment helpers.
// Combinational helpers only; no state, no flow control.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] addr_lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/data shifted into lanes, load data extracted and extended.
// Purely combinational, zero latency, no backpressure.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]        funct3_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [NB-1:0]     mask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [NB-1:0]     size_mask;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        size_mask = '0;
        for (int i = 0; i < NB; i++) begin
            size_mask[i] = (4'(i) < size_bytes(funct3_i[1:0]));
        end
        mask_o  = size_mask << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
        shifted = rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_LB:   rdata_o = DATA_W'($signed(shifted[7:0]));
            F3_LH:   rdata_o = DATA_W'($signed(shifted[15:0]));
            F3_LW:   rdata_o = DATA_W'($signed(shifted[31:0]));
            F3_LBU:  rdata_o = DATA_W'(shifted[7:0]);
            F3_LHU:  rdata_o = DATA_W'(shifted[15:0]);
            F3_LWU:  rdata_o = DATA_W'(shifted[31:0]);
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit: one access at a time over a req/gnt/rvalid memory port; min latency 3 cycles, trap 2.
// Response is an unstallable pulse; request stalls while busy. LSU_TIMEOUT_EN adds a REQ/WAIT watchdog.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_trap,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic                  o_mem_wen,
    output logic [DATA_W/8-1:0]   o_mem_mask,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [NB-1:0]     mem_mask_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              trap_q;

    logic [NB-1:0]     lane_mask;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              bad_access;
    logic              complete;
    logic              timeout;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i (funct3_q),
        .off_i    (addr_q[OFF_W-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (i_mem_rdata),
        .mask_o   (lane_mask),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // Doubleword and lwu exist only on a 64-bit datapath; signed store sizes do not exist.
    assign bad_access = (funct3_q == 3'b111)
                     || ((DATA_W == 32) && ((funct3_q == F3_LD) || (funct3_q == F3_LWU)))
                     || (we_q && funct3_q[2])
                     || is_misaligned(funct3_q[1:0], addr_q[2:0]);

    assign complete = ((state_q == ST_REQ) && i_mem_gnt && i_mem_rvalid)
                   || ((state_q == ST_WAIT) && i_mem_rvalid);

`ifdef LSU_TIMEOUT_EN
    logic [15:0] wdog_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wdog_q <= '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
            wdog_q <= wdog_q + 16'd1;
        end else begin
            wdog_q <= '0;
        end
    end

    assign timeout = ((state_q == ST_REQ) || (state_q == ST_WAIT))
                  && (wdog_q >= 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_req_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = bad_access ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (complete)       state_d = ST_RESP;
                else if (i_mem_gnt) state_d = ST_WAIT;
                else if (timeout)   state_d = ST_RESP;
            end
            ST_WAIT:  if (complete || timeout) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        o_mem_req   = (state_q == ST_REQ);
        o_rsp_valid = (state_q == ST_RESP);
        o_rsp_trap  = (state_q == ST_RESP) && trap_q;
        o_rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wen   = we_q;
    assign o_mem_mask  = mem_mask_q;
    assign o_mem_wdata = mem_wdata_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_mask_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            trap_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        we_q     <= i_req_we;
                        funct3_q <= i_req_funct3;
                        addr_q   <= i_req_addr;
                        wdata_q  <= i_req_wdata;
                    end
                end
                ST_CHECK: begin
                    rdata_q <= '0;
                    trap_q  <= bad_access;
                    if (!bad_access) begin
                        mem_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_mask_q  <= lane_mask;
                        mem_wdata_q <= lane_wdata;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (complete) begin
                        trap_q  <= i_mem_err;
                        rdata_q <= (i_mem_err || we_q) ? '0 : lane_rdata;
                    end else if (timeout) begin
                        trap_q  <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port on a 32-bit and a 64-bit instance (the latter with an 8-cycle watchdog).
module tb_lsu_mem_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_trap;
    logic [2:0]  a_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_req, a_mem_gnt, a_mem_wen, a_mem_rvalid, a_mem_err;
    logic [3:0]  a_mem_mask;

    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_trap;
    logic [2:0]  b_funct3;
    logic [31:0] b_req_addr, b_mem_addr;
    logic [63:0] b_req_wdata, b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_mem_req, b_mem_gnt, b_mem_wen, b_mem_rvalid, b_mem_err;
    logic [7:0]  b_mem_mask;

    int vectors = 0;
    int errs    = 0;

    lsu_mem_port #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .i_clk(clk), .i_rst_n(a_rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
        .i_req_funct3(a_funct3), .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
        .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rsp_rdata), .o_rsp_trap(a_rsp_trap),
        .o_mem_req(a_mem_req), .i_mem_gnt(a_mem_gnt), .o_mem_addr(a_mem_addr),
        .o_mem_wen(a_mem_wen), .o_mem_mask(a_mem_mask), .o_mem_wdata(a_mem_wdata),
        .i_mem_rvalid(a_mem_rvalid), .i_mem_rdata(a_mem_rdata), .i_mem_err(a_mem_err)
    );

    lsu_mem_port #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut64 (
        .i_clk(clk), .i_rst_n(b_rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
        .i_req_funct3(b_funct3), .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata), .o_rsp_trap(b_rsp_trap),
        .o_mem_req(b_mem_req), .i_mem_gnt(b_mem_gnt), .o_mem_addr(b_mem_addr),
        .o_mem_wen(b_mem_wen), .o_mem_mask(b_mem_mask), .o_mem_wdata(b_mem_wdata),
        .i_mem_rvalid(b_mem_rvalid), .i_mem_rdata(b_mem_rdata), .i_mem_err(b_mem_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit w64, input bit v, input bit we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [63:0] wd);
        if (w64) begin
            b_req_valid = v; b_req_we = we; b_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = v; a_req_we = we; a_funct3 = f3; a_req_addr = addr; a_req_wdata = wd[31:0];
        end
    endtask

    task automatic drive_mem(input bit w64, input bit gnt, input bit rv, input logic [63:0] rd, input bit err);
        if (w64) begin
            b_mem_gnt = gnt; b_mem_rvalid = rv; b_mem_rdata = rd; b_mem_err = err;
        end else begin
            a_mem_gnt = gnt; a_mem_rvalid = rv; a_mem_rdata = rd[31:0]; a_mem_err = err;
        end
    endtask

    // One transaction; memory grants after gnt_dly REQ cycles, rvalid with gnt or one cycle later.
    task automatic xact(input bit w64, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wdata, input int gnt_dly, input bit rv_with_gnt,
                        input logic [63:0] rdata, input bit err,
                        output int lat, output bit saw_req, output bit stable, output bit wen,
                        output logic [7:0] mask, output logic [31:0] maddr, output logic [63:0] mwdata,
                        output bit trap, output logic [63:0] rd, output bit mreq_at_rsp);
        bit pend;
        int reqcnt;
        lat = -1; saw_req = 0; stable = 1; wen = 0; mask = '0; maddr = '0; mwdata = '0;
        trap = 0; rd = '0; mreq_at_rsp = 0; pend = 0; reqcnt = 0;
        @(negedge clk);
        drive_req(w64, 1'b1, we, f3, addr, wdata);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            drive_req(w64, 1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
            drive_mem(w64, 1'b0, 1'b0, 64'h0, 1'b0);
            if (w64 ? b_rsp_valid : a_rsp_valid) begin
                lat         = k;
                trap        = w64 ? b_rsp_trap : a_rsp_trap;
                rd          = w64 ? b_rsp_rdata : 64'(a_rsp_rdata);
                mreq_at_rsp = w64 ? b_mem_req : a_mem_req;
                break;
            end
            if (w64 ? b_mem_req : a_mem_req) begin
                if (!saw_req) begin
                    saw_req = 1;
                    wen     = w64 ? b_mem_wen : a_mem_wen;
                    mask    = w64 ? b_mem_mask : 8'(a_mem_mask);
                    maddr   = w64 ? b_mem_addr : a_mem_addr;
                    mwdata  = w64 ? b_mem_wdata : 64'(a_mem_wdata);
                end else if ((wen != (w64 ? b_mem_wen : a_mem_wen))
                          || (mask != (w64 ? b_mem_mask : 8'(a_mem_mask)))
                          || (maddr != (w64 ? b_mem_addr : a_mem_addr))
                          || (mwdata != (w64 ? b_mem_wdata : 64'(a_mem_wdata)))) begin
                    stable = 0;
                end
                if (reqcnt == gnt_dly) begin
                    if (rv_with_gnt) drive_mem(w64, 1'b1, 1'b1, rdata, err);
                    else begin
                        drive_mem(w64, 1'b1, 1'b0, 64'h0, 1'b0);
                        pend = 1;
                    end
                end
                reqcnt++;
            end else if (pend) begin
                drive_mem(w64, 1'b0, 1'b1, rdata, err);
                pend = 0;
            end
        end
    endtask

    initial begin : main
        int          lat;
        bit          saw, stb, wen, trap, mrq;
        logic [7:0]  mk;
        logic [31:0] ma;
        logic [63:0] mw, rd;

        a_rst_n = 0; b_rst_n = 0;
        drive_req(0, 0, 0, 3'b000, 0, 0); drive_mem(0, 0, 0, 0, 0);
        drive_req(1, 0, 0, 3'b000, 0, 0); drive_mem(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst32_ready", 64'(a_req_ready), 64'h1);
        check("rst32_ctl", 64'({a_rsp_valid, a_rsp_trap, a_mem_req}), 64'h0);
        check("rst32_rdata", 64'(a_rsp_rdata), 64'h0);
        check("rst32_mem", {a_mem_addr, a_mem_wdata}, 64'h0);
        check("rst32_mask", 64'(a_mem_mask), 64'h0);
        check("rst64_ready", 64'(b_req_ready), 64'h1);
        check("rst64_mask", 64'(b_mem_mask), 64'h0);
        a_rst_n = 1; b_rst_n = 1;

        // lw 0x100, zero-wait memory
        xact(0, 0, 3'b010, 32'h100, 0, 0, 1, 64'hDEADBEEF, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lw_lat", 64'(lat), 64'd3);
        check("lw_mask", 64'(mk), 64'h0F);
        check("lw_addr", 64'(ma), 64'h100);
        check("lw_rdata", rd, 64'hDEADBEEF);
        check("lw_trap", 64'(trap), 64'h0);
        @(negedge clk);
        check("rsp_pulse", 64'({a_rsp_valid, a_req_ready}), 64'h1);

        xact(0, 0, 3'b000, 32'h103, 0, 0, 0, 64'h80123456, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lb_mask", 64'(mk), 64'h08);
        check("lb_addr", 64'(ma), 64'h100);
        check("lb_rdata", rd, 64'hFFFFFF80);
        check("lb_lat", 64'(lat), 64'd4);

        xact(0, 0, 3'b100, 32'h103, 0, 0, 0, 64'h80123456, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lbu_rdata", rd, 64'h00000080);

        xact(0, 0, 3'b001, 32'h102, 0, 0, 0, 64'h80017777, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lh_mask", 64'(mk), 64'h0C);
        check("lh_rdata", rd, 64'hFFFF8001);

        // sh with the grant held off for 4 REQ cycles
        xact(0, 1, 3'b001, 32'h102, 64'h1234ABCD, 4, 0, 64'hFFFFFFFF, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("sh_mask", 64'(mk), 64'h0C);
        check("sh_wdata", mw, 64'hABCD0000);
        check("sh_addr", 64'(ma), 64'h100);
        check("sh_wen", 64'(wen), 64'h1);
        check("sh_stable", 64'(stb), 64'h1);
        check("sh_lat", 64'(lat), 64'd8);
        check("sh_rsp", {rd[62:0], trap}, 64'h0);

        xact(0, 0, 3'b010, 32'h101, 0, 0, 1, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("mis_noreq", 64'(saw), 64'h0);
        check("mis_trap", 64'(trap), 64'h1);
        check("mis_lat", 64'(lat), 64'd2);
        check("mis_rdata", rd, 64'h0);

        xact(0, 0, 3'b011, 32'h108, 0, 0, 1, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("ld32_trap", 64'({saw, trap}), 64'h1);

        xact(0, 1, 3'b100, 32'h100, 64'h11, 0, 1, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("sbu_trap", 64'({saw, trap}), 64'h1);

        xact(0, 1, 3'b010, 32'h104, 64'h55AA55AA, 0, 0, 64'h0, 1, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("sw_err_mem", {ma, mw[31:0]}, 64'h00000104_55AA55AA);
        check("sw_err_trap", 64'(trap), 64'h1);
        check("sw_err_lat", 64'(lat), 64'd4);

        // 64-bit datapath
        xact(1, 0, 3'b011, 32'h8, 0, 0, 0, 64'h0123456789ABCDEF, 1, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("ld_err_mask", 64'(mk), 64'hFF);
        check("ld_err_addr", 64'(ma), 64'h8);
        check("ld_err_trap", 64'(trap), 64'h1);
        check("ld_err_rdata", rd, 64'h0);

        xact(1, 0, 3'b011, 32'h8, 0, 0, 1, 64'h0123456789ABCDEF, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("ld_rdata", rd, 64'h0123456789ABCDEF);
        check("ld_lat", 64'(lat), 64'd3);

        xact(1, 0, 3'b110, 32'hC, 0, 0, 0, 64'hF0000000_12345678, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lwu_mask", 64'(mk), 64'hF0);
        check("lwu_rdata", rd, 64'h00000000_F0000000);

        xact(1, 0, 3'b010, 32'hC, 0, 0, 0, 64'hF0000000_12345678, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("lw64_rdata", rd, 64'hFFFFFFFF_F0000000);

        xact(1, 1, 3'b011, 32'h10, 64'h1122334455667788, 1, 0, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("sd_mask", 64'(mk), 64'hFF);
        check("sd_wdata", mw, 64'h1122334455667788);

        xact(1, 1, 3'b010, 32'h14, 64'hCAFEBABE, 0, 1, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("sw64_mask", 64'(mk), 64'hF0);
        check("sw64_wdata", mw, 64'hCAFEBABE_00000000);
        check("sw64_addr", 64'(ma), 64'h10);

        // reset while waiting for rvalid
        @(negedge clk); drive_req(1, 1, 0, 3'b011, 32'h8, 0);
        @(negedge clk); drive_req(1, 0, 0, 3'b000, 0, 0);
        @(negedge clk);
        check("rstw_req", 64'(b_mem_req), 64'h1);
        b_mem_gnt = 1;
        @(negedge clk);
        b_mem_gnt = 0;
        check("rstw_wait", 64'({b_mem_req, b_req_ready}), 64'h0);
        b_rst_n = 0;
        @(negedge clk);
        b_rst_n = 1;
        check("rstw_idle", 64'({b_req_ready, b_rsp_valid, b_mem_req}), 64'h4);
        drive_mem(1, 0, 1, 64'h5555, 0);
        @(negedge clk);
        drive_mem(1, 0, 0, 0, 0);
        check("rstw_norsp", 64'({b_req_ready, b_rsp_valid}), 64'h2);

`ifdef LSU_TIMEOUT_EN
        xact(1, 0, 3'b000, 32'h8, 0, 1000, 0, 64'h0, 0, lat, saw, stb, wen, mk, ma, mw, trap, rd, mrq);
        check("tmo_lat", 64'(lat), 64'd10);
        check("tmo_trap", 64'(trap), 64'h1);
        check("tmo_memreq", 64'(mrq), 64'h0);
        check("tmo_rdata", rd, 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
